// File: rtl/serial_byte_assembler.sv
// serial_byte_assembler: receive-side deserializer for the bit-serial byte link.
// Collects 1-bit serial samples (valid/ready) into a WIDTH-bit word presented
// on a registered valid/ready output. MSB_FIRST selects the serial bit order.
// Optional feature macro: SERIAL_BYTE_ASSEMBLER_PARITY_CHECK_EN adds a trailing
// even-parity bit to each serial word and reports mismatches on par_err.
module serial_byte_assembler #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ser_valid,
    input  logic             ser_data,
    output logic             ser_ready,
    input  logic             frame_start,
    output logic [WIDTH-1:0] par_data,
    output logic             par_valid,
    input  logic             par_ready,
    output logic             sync_err,
    output logic             par_err
);

`ifdef SERIAL_BYTE_ASSEMBLER_PARITY_CHECK_EN
    localparam int L = WIDTH + 1;
`else
    localparam int L = WIDTH;
`endif
    localparam int            CW   = $clog2(L);
    localparam logic [CW-1:0] LAST = CW'(L - 1);

    typedef enum logic {
        EMPTY,
        FULL
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic [CW-1:0]    pos;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;
    logic [WIDTH-1:0] word;
    logic             accept;
    logic             word_done;
    logic             pop;

    assign par_valid = (state == FULL);
    assign pop       = par_valid && par_ready;
    // Only the word-completing bit can collide with an unconsumed output word.
    assign ser_ready = !((count == LAST) && par_valid && !par_ready);
    assign accept    = ser_valid && ser_ready;

    // Bit placement and count advance; frame_start restarts the word so that
    // a bit accepted alongside it lands at position 0 of a fresh word.
    always_comb begin
        pos       = frame_start ? '0 : count;
        word      = frame_start ? '0 : shreg;
        count_nxt = pos;
        word_done = 1'b0;
        if (accept) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (32'(pos) == (MSB_FIRST ? (WIDTH - 1 - i) : i)) begin
                    word[i] = ser_data;
                end
            end
            if (pos == LAST) begin
                word_done = 1'b1;
                count_nxt = '0;
            end else begin
                count_nxt = pos + 1'b1;
            end
        end
        shreg_nxt = word_done ? '0 : word;
    end

    // Output FSM next state: a load always leaves the output full.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (word_done) state_nxt = FULL;
            FULL:    if (pop && !word_done) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    // State, collection and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= EMPTY;
            count    <= '0;
            shreg    <= '0;
            par_data <= '0;
            sync_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            shreg    <= shreg_nxt;
            sync_err <= frame_start && (count != '0);
            if (word_done) begin
                par_data <= word;
            end
        end
    end

`ifdef SERIAL_BYTE_ASSEMBLER_PARITY_CHECK_EN
    // Parity flag loads together with par_data; ser_data is the parity bit here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_err <= 1'b0;
        end else if (word_done) begin
            par_err <= (^word) ^ ser_data;
        end
    end
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_byte_assembler.sv
// tb_serial_byte_assembler: scoreboard bench driving an MSB-first and an
// LSB-first instance with the same serial stream. Honours the
// SERIAL_BYTE_ASSEMBLER_PARITY_CHECK_EN macro like the design does.
module tb_serial_byte_assembler;

`ifdef SERIAL_BYTE_ASSEMBLER_PARITY_CHECK_EN
    localparam int TB_L = 9;
`else
    localparam int TB_L = 8;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       ser_valid;
    logic       ser_data;
    logic       frame_start;
    logic       par_ready;
    logic       ser_ready_m, ser_ready_l;
    logic [7:0] par_data_m, par_data_l;
    logic       par_valid_m, par_valid_l;
    logic       sync_err_m, sync_err_l;
    logic       par_err_m, par_err_l;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_sync  = 0;
    int         n_pop_m = 0;
    logic [8:0] exp_m[$];
    logic [8:0] exp_l[$];

    int         tb_cnt = 0;
    logic [7:0] m_word = '0;
    logic [7:0] l_word = '0;
    logic       pbit   = 1'b0;

    always #5 clk = ~clk;

    serial_byte_assembler #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk(clk), .reset(reset), .ser_valid(ser_valid), .ser_data(ser_data),
        .ser_ready(ser_ready_m), .frame_start(frame_start), .par_data(par_data_m),
        .par_valid(par_valid_m), .par_ready(par_ready), .sync_err(sync_err_m),
        .par_err(par_err_m)
    );

    serial_byte_assembler #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk(clk), .reset(reset), .ser_valid(ser_valid), .ser_data(ser_data),
        .ser_ready(ser_ready_l), .frame_start(frame_start), .par_data(par_data_l),
        .par_valid(par_valid_l), .par_ready(par_ready), .sync_err(sync_err_l),
        .par_err(par_err_l)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic stream_bit(input logic [7:0] w, input int k, input logic pflip);
        logic [7:0] v;
        v = w;
        if (k < 8) return v[7 - k];
        return (^v) ^ pflip;
    endfunction

    // One serial bit: wait (bounded) for ready, then update the reference model.
    task automatic send_bit(input logic b, input logic fs);
        int waits = 0;
        ser_valid   = 1'b1;
        ser_data    = b;
        frame_start = fs;
        @(negedge clk);
        while (!(ser_ready_m && ser_ready_l) && waits < 40) begin
            waits++;
            @(negedge clk);
        end
        check("accept_wait", 32'(waits < 40), 32'(1));
        @(posedge clk);
        if (fs) begin
            tb_cnt = 0;
            m_word = '0;
            l_word = '0;
        end
        if (tb_cnt < 8) begin
            m_word = {m_word[6:0], b};
            l_word[tb_cnt[2:0]] = b;
        end else begin
            pbit = b;
        end
        tb_cnt++;
        if (tb_cnt == TB_L) begin
`ifdef SERIAL_BYTE_ASSEMBLER_PARITY_CHECK_EN
            exp_m.push_back({(^m_word) ^ pbit, m_word});
            exp_l.push_back({(^l_word) ^ pbit, l_word});
`else
            exp_m.push_back({1'b0, m_word});
            exp_l.push_back({1'b0, l_word});
`endif
            tb_cnt = 0;
            m_word = '0;
            l_word = '0;
        end
        #1;
        ser_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input logic fs, input logic pflip);
        for (int k = 0; k < TB_L; k++) begin
            send_bit(stream_bit(w, k, pflip), fs && (k == 0));
            if (fs && k == 0) check("sync_err_pulse", 32'(sync_err_m), 32'(1));
            if (fs && k == 1) check("sync_err_end", 32'(sync_err_m), 32'(0));
        end
    endtask

    // Scoreboard: pop and compare whenever an output handshake will occur.
    always @(negedge clk) begin
        logic [8:0] e;
        if (!reset) begin
            if (sync_err_m) n_sync++;
            if (par_valid_m && par_ready) begin
                check("m_word_expected", 32'(exp_m.size() != 0), 32'(1));
                if (exp_m.size() != 0) begin
                    e = exp_m.pop_front();
                    check("m_data", 32'(par_data_m), 32'(e[7:0]));
                    check("m_err", 32'(par_err_m), 32'(e[8]));
                    n_pop_m++;
                end
            end
            if (par_valid_l && par_ready) begin
                check("l_word_expected", 32'(exp_l.size() != 0), 32'(1));
                if (exp_l.size() != 0) begin
                    e = exp_l.pop_front();
                    check("l_data", 32'(par_data_l), 32'(e[7:0]));
                    check("l_err", 32'(par_err_l), 32'(e[8]));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pops_before;
        reset       = 1'b1;
        ser_valid   = 1'b0;
        ser_data    = 1'b0;
        frame_start = 1'b0;
        par_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_par_valid", 32'(par_valid_m), 32'(0));
        check("rst_par_data", 32'(par_data_m), 32'(0));
        check("rst_sync_err", 32'(sync_err_m), 32'(0));
        check("rst_par_err", 32'(par_err_m), 32'(0));
        check("rst_ser_ready", 32'(ser_ready_m), 32'(1));
        reset = 1'b0;

        // Bits 1,0,1,1,0,0,1,0: MSB-first 8'hB2, LSB-first 8'h4D, 1 clk latency.
        send_word(8'hB2, 1'b0, 1'b0);
        check("t1_valid_latency", 32'(par_valid_m), 32'(1));
        check("t1_data_msb", 32'(par_data_m), 32'(8'hB2));
        check("t2_data_lsb", 32'(par_data_l), 32'(8'h4D));
        check("t2_valid_lsb", 32'(par_valid_l), 32'(1));
        @(posedge clk); #1;
        check("t1_valid_one_cycle", 32'(par_valid_m), 32'(0));

        // Back-pressure: A held, B collected, last B bit stalls until A pops.
        @(posedge clk); #1;
        par_ready = 1'b0;
        send_word(8'hB2, 1'b0, 1'b0);
        for (int k = 0; k < TB_L - 1; k++) send_bit(stream_bit(8'h3C, k, 1'b0), 1'b0);
        fork
            send_bit(stream_bit(8'h3C, TB_L - 1, 1'b0), 1'b0);
            begin
                @(negedge clk);
                check("t3_ser_ready_low", 32'(ser_ready_m), 32'(0));
                check("t3_hold_data", 32'(par_data_m), 32'(8'hB2));
                repeat (2) @(negedge clk);
                check("t3_still_held", 32'(par_valid_m), 32'(1));
                check("t3_hold_data2", 32'(par_data_m), 32'(8'hB2));
                @(posedge clk); #1;
                par_ready = 1'b1;
            end
        join
        check("t3_b_loaded", 32'(par_data_m), 32'(8'h3C));
        check("t3_b_valid", 32'(par_valid_m), 32'(1));
        repeat (2) @(posedge clk); #1;

        // Resync after 3 bits: the frame_start bit starts the new word.
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_word(8'h96, 1'b1, 1'b0);
        check("t4_word", 32'(par_data_m), 32'(8'h96));
        repeat (2) @(posedge clk); #1;

        // Reset with a held word and a partial word in flight.
        par_ready = 1'b0;
        send_word(8'hA5, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) send_bit(stream_bit(8'h5A, k, 1'b0), 1'b0);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("t5_async_valid", 32'(par_valid_m), 32'(0));
        check("t5_async_data", 32'(par_data_m), 32'(0));
        check("t5_async_data_l", 32'(par_data_l), 32'(0));
        check("t5_no_sync_err", 32'(sync_err_m), 32'(0));
        exp_m.delete();
        exp_l.delete();
        tb_cnt = 0;
        m_word = '0;
        l_word = '0;
        @(posedge clk); #1;
        reset     = 1'b0;
        par_ready = 1'b1;
        pops_before = n_pop_m;
        send_word(8'h5A, 1'b0, 1'b0);
        repeat (4) @(posedge clk); #1;
        check("t5_one_word", 32'(n_pop_m - pops_before), 32'(1));

`ifdef SERIAL_BYTE_ASSEMBLER_PARITY_CHECK_EN
        // Parity: correct even parity, then a flipped parity bit.
        send_word(8'hB2, 1'b0, 1'b0);
        check("t6_err_clear", 32'(par_err_m), 32'(0));
        check("t6_data_a", 32'(par_data_m), 32'(8'hB2));
        send_word(8'hB2, 1'b0, 1'b1);
        check("t6_err_set", 32'(par_err_m), 32'(1));
        check("t6_data_b", 32'(par_data_m), 32'(8'hB2));
        repeat (2) @(posedge clk); #1;
`endif

        check("sb_drained_m", 32'(exp_m.size()), 32'(0));
        check("sb_drained_l", 32'(exp_l.size()), 32'(0));
        check("sync_err_total", 32'(n_sync), 32'(1));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
